// File: rtl/aim_shot_controller.sv
// Cue aiming stage: steps aim angle and shot power from held keys once per frame,
// drives the direction-line vector, and fires a one-cycle shot strobe on Enter.
module aim_shot_controller #(
  parameter int MIN_POWER     = 8,
  parameter int MAX_POWER     = 200,
  parameter int POWER_STEP    = 4,
  parameter int INIT_POWER    = 64,
  parameter int REPEAT_FRAMES = 4,
  parameter int SETTLE_FRAMES = 8,
  parameter int MOVE_TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               keyUp,
  input  logic               keyDown,
  input  logic               keyEnter,
  input  logic               ballsMoving,
  output logic               lineEnable,
  output logic signed [10:0] velocityX,
  output logic signed [10:0] velocityY,
  output logic               shotValid,
  output logic signed [10:0] shotVelX,
  output logic signed [10:0] shotVelY
);

  localparam int HW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_FRAMES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);
  localparam logic [MW-1:0] MOVE_LAST   = MW'(MOVE_TIMEOUT - 1);
  localparam logic [9:0]    MIN_P       = 10'(MIN_POWER);
  localparam logic [9:0]    MAX_P       = 10'(MAX_POWER);
  localparam logic [9:0]    STEP_P      = 10'(POWER_STEP);
  localparam logic [9:0]    INIT_P      = 10'(INIT_POWER);

  typedef enum logic [1:0] {AIM, FIRE, WAIT_MOVE, WAIT_STOP} state_e;

  state_e             state_q, state_d;
  logic [5:0]         angle_q, angle_d;
  logic [9:0]         power_q, power_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [MW-1:0]      move_q, move_d;
  logic               enter_prev_q, enter_prev_d;
  logic               stale1_q, stale1_d, stale2_q, stale2_d;
  logic               line_en_q, line_en_d;
  logic               shot_valid_q, shot_valid_d;
  logic signed [10:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic [9:0]         mag_x_q, mag_x_d, mag_y_q, mag_y_d;
  logic               neg_x_q, neg_x_d, neg_y_q, neg_y_d;
  logic signed [10:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [4:0]         s_idx, c_idx;
  logic [6:0]         s_abs, c_abs;
  logic               any_key, param_change, fire;

  // First quadrant of round(64*sin(k*pi/32)); the other quadrants fold onto it.
  function automatic logic [6:0] sin_rom(input logic [4:0] k);
    logic [6:0] v;
    case (k)
      5'd0:    v = 7'd0;
      5'd1:    v = 7'd6;
      5'd2:    v = 7'd12;
      5'd3:    v = 7'd19;
      5'd4:    v = 7'd24;
      5'd5:    v = 7'd30;
      5'd6:    v = 7'd36;
      5'd7:    v = 7'd41;
      5'd8:    v = 7'd45;
      5'd9:    v = 7'd49;
      5'd10:   v = 7'd53;
      5'd11:   v = 7'd56;
      5'd12:   v = 7'd59;
      5'd13:   v = 7'd61;
      5'd14:   v = 7'd63;
      5'd15:   v = 7'd64;
      5'd16:   v = 7'd64;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  assign any_key = keyLeft | keyRight | keyUp | keyDown;

  // Stage 1: quadrant fold, ROM lookup and power multiply (truncated magnitude).
  always_comb begin
    s_idx   = angle_q[4] ? (5'd16 - {1'b0, angle_q[3:0]}) : {1'b0, angle_q[3:0]};
    c_idx   = angle_q[4] ? {1'b0, angle_q[3:0]} : (5'd16 - {1'b0, angle_q[3:0]});
    s_abs   = sin_rom(s_idx);
    c_abs   = sin_rom(c_idx);
    neg_x_d = angle_q[5] ^ angle_q[4];
    neg_y_d = ~angle_q[5];  // screen Y grows down, so positive sine draws upward
    mag_x_d = 10'((16'(power_q) * 16'(c_abs)) >> 6);
    mag_y_d = 10'((16'(power_q) * 16'(s_abs)) >> 6);
  end

  // Stage 2: apply sign.
  always_comb begin
    vel_x_d = neg_x_q ? -$signed({1'b0, mag_x_q}) : $signed({1'b0, mag_x_q});
    vel_y_d = neg_y_q ? -$signed({1'b0, mag_y_q}) : $signed({1'b0, mag_y_q});
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    angle_d      = angle_q;
    power_d      = power_q;
    hold_d       = hold_q;
    settle_d     = settle_q;
    move_d       = move_q;
    shot_x_d     = shot_x_q;
    shot_y_d     = shot_y_q;
    param_change = 1'b0;
    fire         = 1'b0;
    case (state_q)
      AIM: begin
        if (startOfFrame) begin
          if (any_key) begin
            hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
            if (hold_q == '0) begin
              if (keyLeft && !keyRight)      angle_d = angle_q + 6'd1;
              else if (keyRight && !keyLeft) angle_d = angle_q - 6'd1;
              if (keyUp && !keyDown)
                power_d = (power_q >= MAX_P - STEP_P) ? MAX_P : power_q + STEP_P;
              else if (keyDown && !keyUp)
                power_d = (power_q <= MIN_P + STEP_P) ? MIN_P : power_q - STEP_P;
            end
          end else begin
            hold_d = '0;
          end
        end
        // A shot must capture a settled vector, so Enter is dropped while the pipe refills.
        param_change = (angle_d != angle_q) || (power_d != power_q);
        fire = keyEnter && !enter_prev_q && !stale1_q && !stale2_q && !param_change;
        if (fire) begin
          state_d  = FIRE;
          shot_x_d = vel_x_q;
          shot_y_d = vel_y_q;
          hold_d   = '0;
        end
      end
      FIRE: begin
        state_d = WAIT_MOVE;
        move_d  = '0;
      end
      WAIT_MOVE: begin
        if (ballsMoving) begin
          state_d  = WAIT_STOP;
          settle_d = '0;
        end else if (startOfFrame) begin
          if (move_q == MOVE_LAST) state_d = AIM;
          else                     move_d  = move_q + 1'b1;
        end
      end
      WAIT_STOP: begin
        if (startOfFrame) begin
          if (ballsMoving) begin
            settle_d = '0;
          end else if (settle_q == SETTLE_LAST) begin
            state_d  = AIM;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      default: state_d = AIM;
    endcase
    stale1_d     = param_change;
    stale2_d     = stale1_q;
    enter_prev_d = keyEnter;
    line_en_d    = (state_d == AIM);
    shot_valid_d = (state_d == FIRE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= AIM;
      angle_q      <= '0;
      power_q      <= INIT_P;
      hold_q       <= '0;
      settle_q     <= '0;
      move_q       <= '0;
      enter_prev_q <= 1'b1;
      stale1_q     <= 1'b1;
      stale2_q     <= 1'b1;
      line_en_q    <= 1'b0;
      shot_valid_q <= 1'b0;
      shot_x_q     <= '0;
      shot_y_q     <= '0;
      mag_x_q      <= '0;
      mag_y_q      <= '0;
      neg_x_q      <= 1'b0;
      neg_y_q      <= 1'b0;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      power_q      <= power_d;
      hold_q       <= hold_d;
      settle_q     <= settle_d;
      move_q       <= move_d;
      enter_prev_q <= enter_prev_d;
      stale1_q     <= stale1_d;
      stale2_q     <= stale2_d;
      line_en_q    <= line_en_d;
      shot_valid_q <= shot_valid_d;
      shot_x_q     <= shot_x_d;
      shot_y_q     <= shot_y_d;
      mag_x_q      <= mag_x_d;
      mag_y_q      <= mag_y_d;
      neg_x_q      <= neg_x_d;
      neg_y_q      <= neg_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
    end
  end

  assign lineEnable = line_en_q;
  assign shotValid  = shot_valid_q;
  assign velocityX  = vel_x_q;
  assign velocityY  = vel_y_q;
  assign shotVelX   = shot_x_q;
  assign shotVelY   = shot_y_q;

endmodule

// File: tb/tb_aim_shot_controller.sv
// Self-checking bench for aim_shot_controller: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a behavioural model.
module tb_aim_shot_controller;

  localparam int REPEAT  = 4;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 16;
  localparam int PMIN    = 8;
  localparam int PMAX    = 200;
  localparam int PSTEP   = 4;
  localparam int PINIT   = 64;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic keyLeft = 1'b0, keyRight = 1'b0, keyUp = 1'b0, keyDown = 1'b0;
  logic keyEnter = 1'b0, ballsMoving = 1'b0;
  logic lineEnable, shotValid;
  logic signed [10:0] velocityX, velocityY, shotVelX, shotVelY;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  aim_shot_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .keyLeft(keyLeft), .keyRight(keyRight), .keyUp(keyUp), .keyDown(keyDown),
    .keyEnter(keyEnter), .ballsMoving(ballsMoving),
    .lineEnable(lineEnable), .velocityX(velocityX), .velocityY(velocityY),
    .shotValid(shotValid), .shotVelX(shotVelX), .shotVelY(shotVelY)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_AIM, PH_SHOT, PH_AWAIT_MOTION, PH_AWAIT_REST} phase_e;
  phase_e m_phase;
  int m_angle, m_power, m_hold, m_idle, m_quiet, m_edge, m_last_change;
  int m_s1x, m_s1y, m_vx, m_vy, m_shx, m_shy;
  bit m_prev_enter, m_line, m_strobe;

  function automatic void aim_vec(input int ang, input int pw, output int vx, output int vy);
    real c, s;
    int cm, sm;
    c  = $cos(ang * 3.141592653589793 / 32.0);
    s  = $sin(ang * 3.141592653589793 / 32.0);
    cm = $rtoi((c < 0.0 ? -c : c) * 64.0 + 0.5);
    sm = $rtoi((s < 0.0 ? -s : s) * 64.0 + 0.5);
    vx = (pw * cm) >> 6;
    if (c < 0.0) vx = -vx;
    vy = (pw * sm) >> 6;
    if (s > 0.0) vy = -vy;
  endfunction

  task automatic model_reset();
    m_phase = PH_AIM; m_angle = 0; m_power = PINIT; m_hold = 0;
    m_idle = 0; m_quiet = 0; m_edge = 0; m_last_change = 0;
    m_s1x = 0; m_s1y = 0; m_vx = 0; m_vy = 0; m_shx = 0; m_shy = 0;
    m_prev_enter = 1'b1; m_line = 1'b0; m_strobe = 1'b0;
  endtask

  task automatic model_step();
    int na, np, nvx, nvy, fx, fy;
    bit change;
    m_edge++;
    nvx = m_s1x;
    nvy = m_s1y;
    aim_vec(m_angle, m_power, fx, fy);
    m_s1x = fx;
    m_s1y = fy;
    na = m_angle;
    np = m_power;
    case (m_phase)
      PH_AIM: begin
        if (startOfFrame) begin
          if (keyLeft || keyRight || keyUp || keyDown) begin
            if (m_hold == 0) begin
              if (keyLeft && !keyRight) na = (m_angle + 1) % 64;
              if (keyRight && !keyLeft) na = (m_angle + 63) % 64;
              if (keyUp && !keyDown)    np = (m_power + PSTEP > PMAX) ? PMAX : m_power + PSTEP;
              if (keyDown && !keyUp)    np = (m_power - PSTEP < PMIN) ? PMIN : m_power - PSTEP;
            end
            m_hold = (m_hold + 1) % REPEAT;
          end else begin
            m_hold = 0;
          end
        end
        change = (na != m_angle) || (np != m_power);
        if (change) begin
          m_last_change = m_edge;
        end else if (keyEnter && !m_prev_enter && (m_edge - m_last_change >= 3)) begin
          m_phase = PH_SHOT;
          m_shx = m_vx;
          m_shy = m_vy;
        end
        m_angle = na;
        m_power = np;
      end
      PH_SHOT: begin
        m_phase = PH_AWAIT_MOTION;
        m_idle = 0;
      end
      PH_AWAIT_MOTION: begin
        if (ballsMoving) begin
          m_phase = PH_AWAIT_REST;
          m_quiet = 0;
        end else if (startOfFrame) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_phase = PH_AIM; m_hold = 0; end
        end
      end
      PH_AWAIT_REST: begin
        if (startOfFrame) begin
          if (ballsMoving) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == SETTLE) begin m_phase = PH_AIM; m_hold = 0; m_quiet = 0; end
          end
        end
      end
      default: m_phase = PH_AIM;
    endcase
    m_prev_enter = keyEnter;
    m_vx = nvx;
    m_vy = nvy;
    m_line = (m_phase == PH_AIM);
    m_strobe = (m_phase == PH_SHOT);
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) model_reset();
    else         model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_lineEnable", lineEnable, m_line);
      check("cyc_shotValid", shotValid, m_strobe);
      check("cyc_velocityX", $signed(velocityX), m_vx);
      check("cyc_velocityY", $signed(velocityY), m_vy);
      check("cyc_shotVelX", $signed(shotVelX), m_shx);
      check("cyc_shotVelY", $signed(shotVelY), m_shy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    repeat (7) tick();
  endtask

  task automatic check_vec(input string name, input int ex, input int ey);
    check({name, "_x"}, $signed(velocityX), ex);
    check({name, "_y"}, $signed(velocityY), ey);
  endtask

  initial begin
    model_reset();
    // Reset state and pipeline latency
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("reset_lineEnable", lineEnable, 0);
    check("reset_shotValid", shotValid, 0);
    resetN = 1'b1;
    tick();
    check("post_reset_1_vx", $signed(velocityX), 0);
    check("post_reset_1_line", lineEnable, 1);
    tick();
    check_vec("post_reset_2", 64, 0);
    check("post_reset_2_shot", shotValid, 0);

    // Hold left 16 frames -> angle 4
    keyLeft = 1'b1;
    repeat (16) frame();
    keyLeft = 1'b0;
    frame();
    check_vec("angle4", 59, -24);

    keyRight = 1'b1;
    repeat (16) frame();
    keyRight = 1'b0;
    frame();
    check_vec("angle0_back", 64, 0);

    // Fire, then motion for 20 frames, then settle; Enter stays held
    keyEnter = 1'b1;
    tick();
    check("fire_strobe", shotValid, 1);
    check("fire_shot_x", $signed(shotVelX), 64);
    check("fire_shot_y", $signed(shotVelY), 0);
    check("fire_line", lineEnable, 0);
    tick();
    check("fire_strobe_drop", shotValid, 0);
    ballsMoving = 1'b1;
    repeat (20) frame();
    ballsMoving = 1'b0;
    repeat (7) frame();
    check("settle_7_line", lineEnable, 0);
    frame();
    check("settle_8_line", lineEnable, 1);
    repeat (3) frame();
    check("enter_held_no_refire", lineEnable, 1);
    keyEnter = 1'b0;
    tick();

    // Timeout with no motion
    keyEnter = 1'b1;
    tick();
    tick();
    keyEnter = 1'b0;
    repeat (15) frame();
    check("timeout_15_line", lineEnable, 0);
    frame();
    check("timeout_16_line", lineEnable, 1);

    // Motion glitch restarts the settle count
    tick();
    keyEnter = 1'b1;
    tick();
    tick();
    keyEnter = 1'b0;
    ballsMoving = 1'b1;
    repeat (2) frame();
    ballsMoving = 1'b0;
    repeat (5) frame();
    ballsMoving = 1'b1;
    frame();
    ballsMoving = 1'b0;
    repeat (7) frame();
    check("glitch_restart_line", lineEnable, 0);
    frame();
    check("glitch_settled_line", lineEnable, 1);

    // Power saturation and conflicting keys
    keyUp = 1'b1;
    repeat (160) frame();
    keyUp = 1'b0;
    frame();
    check_vec("power_max", 200, 0);
    keyLeft = 1'b1; keyRight = 1'b1;
    repeat (4) frame();
    keyLeft = 1'b0; keyRight = 1'b0;
    frame();
    check_vec("lr_cancel", 200, 0);
    keyRight = 1'b1;
    frame();
    keyRight = 1'b0;
    frame();
    check_vec("angle_wrap_63", 200, 18);
    keyDown = 1'b1;
    repeat (200) frame();
    keyDown = 1'b0;
    frame();
    check_vec("power_min", 8, 0);

    // Reset in WAIT_STOP
    keyEnter = 1'b1;
    tick();
    tick();
    keyEnter = 1'b0;
    ballsMoving = 1'b1;
    frame();
    ballsMoving = 1'b0;
    frame();
    #2 resetN = 1'b0;
    #1;
    check("async_rst_line", lineEnable, 0);
    check("async_rst_shot", shotValid, 0);
    check("async_rst_vx", $signed(velocityX), 0);
    check("async_rst_vy", $signed(velocityY), 0);
    check("async_rst_svx", $signed(shotVelX), 0);
    check("async_rst_svy", $signed(shotVelY), 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    tick();
    tick();
    check_vec("after_rst", 64, 0);
    check("after_rst_line", lineEnable, 1);

    // Randomized stimulus against the model
    for (int i = 0; i < 6000; i++) begin
      startOfFrame = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 2) == 0) {keyLeft, keyRight, keyUp, keyDown} = 4'b0;
        else {keyLeft, keyRight, keyUp, keyDown} = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 40) == 0) ballsMoving = ~ballsMoving;
      if ($urandom_range(0, 9) == 0) keyEnter = ~keyEnter;
      if (i == 3000) begin
        #2 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
